// File: rtl/psram_wq_pkg.sv
// psram_wq_pkg: shared types and constants for the PSRAM write queue
package psram_wq_pkg;
  localparam int PSRAM_AW = 22;
  typedef struct packed {
    logic [PSRAM_AW-1:0] addr;
    logic [7:0]          data;
  } wq_entry_t;
  typedef enum logic [2:0] {IDLE, ISSUE_W, ISSUE_R, WAIT_ACK, WAIT_DONE} wq_state_t;
endpackage

// File: rtl/pamux_if.sv
// pamux_if: client side of the PSRAM access mux (strobes/address/data out, read_data/busy back)
interface pamux_if;
  logic [psram_wq_pkg::PSRAM_AW-1:0] address;
  logic                              write;
  logic                              read;
  logic [7:0]                        write_data;
  logic [7:0]                        read_data;
  logic                              busy;
  modport client (output address, write, read, write_data, input read_data, busy);
  modport mux (input address, write, read, write_data, output read_data, busy);
endinterface

// File: rtl/psram_wq_fifo.sv
// psram_wq_fifo: synchronous FIFO of wq_entry_t; full/empty derived from level
// Ports: clk, rst, push/din, pop/dout (head), full, empty, level (occupancy)
module psram_wq_fifo
  import psram_wq_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wq_entry_t              din,
  input  logic                   pop,
  output wq_entry_t              dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_LVL = DEPTH[PW:0];
  wq_entry_t mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_push, do_pop;
  always_comb begin
    full    = level == FULL_LVL;
    empty   = level == '0;
    do_push = push && !full;
    do_pop  = pop && !empty;
    dout    = mem[rptr];
  end
  always_ff @(posedge clk)
    if (do_push) mem[wptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      wptr  <= wptr + PW'(do_push);
      rptr  <= rptr + PW'(do_pop);
      level <= level + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/psram_write_queue.sv
// psram_write_queue: buffers host byte writes and serves in-order blocking reads over one PSRAM mux port
// Ports: i_CLK/i_RST (sync, active high); wr_req/wr_addr/wr_data/wr_full write push;
//   rd_req/rd_addr/rd_busy/rd_valid/rd_data blocking read; level FIFO occupancy; bus_mem mux client.
// Option PSRAM_WQ_PEAK_EN adds peak_clr input and peak output (max level since reset/clear).
module psram_write_queue
  import psram_wq_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = PSRAM_AW
) (
  input  logic                   i_CLK,
  input  logic                   i_RST,
  input  logic                   wr_req,
  input  logic [AW-1:0]          wr_addr,
  input  logic [7:0]             wr_data,
  output logic                   wr_full,
  input  logic                   rd_req,
  input  logic [AW-1:0]          rd_addr,
  output logic                   rd_busy,
  output logic                   rd_valid,
  output logic [7:0]             rd_data,
  output logic [$clog2(DEPTH):0] level,
`ifdef PSRAM_WQ_PEAK_EN
  input  logic                   peak_clr,
  output logic [$clog2(DEPTH):0] peak,
`endif
  pamux_if.client                bus_mem
);
  wq_state_t state;
  wq_entry_t wr_entry, head;
  logic empty, push, pop, is_rd;
  logic [AW-1:0] rd_addr_q;
  always_comb begin
    wr_entry = '{addr: wr_addr, data: wr_data};
    push     = wr_req && !wr_full;
    pop      = state == ISSUE_W;
  end
  psram_wq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk  (i_CLK),
    .rst  (i_RST),
    .push (wr_req),
    .din  (wr_entry),
    .pop  (pop),
    .dout (head),
    .full (wr_full),
    .empty(empty),
    .level(level)
  );
  // A read issues only with an empty FIFO and no write arriving, so every write
  // accepted before the read strobe reaches PSRAM first.
  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state              <= IDLE;
      is_rd              <= 1'b0;
      rd_busy            <= 1'b0;
      rd_valid           <= 1'b0;
      rd_data            <= '0;
      rd_addr_q          <= '0;
      bus_mem.write      <= 1'b0;
      bus_mem.read       <= 1'b0;
      bus_mem.address    <= '0;
      bus_mem.write_data <= '0;
    end else begin
      rd_valid <= 1'b0;
      if (rd_req && !rd_busy) begin
        rd_busy   <= 1'b1;
        rd_addr_q <= rd_addr;
      end
      case (state)
        IDLE:
          if (!empty && !bus_mem.busy) begin
            state              <= ISSUE_W;
            is_rd              <= 1'b0;
            bus_mem.write      <= 1'b1;
            bus_mem.address    <= head.addr;
            bus_mem.write_data <= head.data;
          end else if (rd_busy && empty && !push && !bus_mem.busy) begin
            state           <= ISSUE_R;
            is_rd           <= 1'b1;
            bus_mem.read    <= 1'b1;
            bus_mem.address <= rd_addr_q;
          end
        ISSUE_W, ISSUE_R: begin
          state              <= WAIT_ACK;
          bus_mem.write      <= 1'b0;
          bus_mem.read       <= 1'b0;
          bus_mem.address    <= '0;
          bus_mem.write_data <= '0;
        end
        WAIT_ACK:
          if (bus_mem.busy) state <= WAIT_DONE;
        WAIT_DONE:
          if (!bus_mem.busy) begin
            state <= IDLE;
            if (is_rd) begin
              rd_data  <= bus_mem.read_data;
              rd_valid <= 1'b1;
              rd_busy  <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef PSRAM_WQ_PEAK_EN
  always_ff @(posedge i_CLK)
    peak <= i_RST ? '0 : (peak_clr || level > peak) ? level : peak;
`endif
endmodule
